// File: rtl/fix_checksum_gate.sv
`default_nettype none
// ============================================================================
//  Module   : fix_checksum_gate
//  Purpose  : Inline FIX checksum monitor. Passes the byte stream through with
//             a fixed one-cycle delay and, alongside it, sums each message
//             from its "8" up to the SOH before "10=", parses the three-digit
//             tag-10 trailer and reports match / malformed status per message.
//  Options  : FIX_CSUM_STATS_EN - adds saturating good/bad message counters;
//             when undefined the counter outputs are constant zero.
//  Revision : 1.0 - initial release
// ============================================================================
module fix_checksum_gate (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        data_valid_i,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        msg_done_o,
  output logic        checksum_ok_o,
  output logic        format_err_o,
  output logic [7:0]  checksum_calc_o,
  output logic [7:0]  checksum_rx_o,
  output logic [15:0] good_cnt_o,
  output logic [15:0] bad_cnt_o
);

  localparam logic [7:0] c_SOH   = 8'h01;
  localparam logic [7:0] c_EIGHT = 8'h38;
  localparam logic [7:0] c_ONE   = 8'h31;
  localparam logic [7:0] c_ZERO  = 8'h30;
  localparam logic [7:0] c_EQ    = 8'h3D;

  localparam logic [1:0] c_S_IDLE    = 2'd0;
  localparam logic [1:0] c_S_BODY    = 2'd1;
  localparam logic [1:0] c_S_TRAILER = 2'd2;

  // Trailer matcher progress: nothing, SOH seen, "1" seen, "10" seen.
  localparam logic [1:0] c_M_NONE = 2'd0;
  localparam logic [1:0] c_M_SOH  = 2'd1;
  localparam logic [1:0] c_M_ONE  = 2'd2;
  localparam logic [1:0] c_M_ZERO = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_state_next;

  logic [7:0] r_sum;
  logic [7:0] r_snap;
  logic [1:0] r_match;
  logic [9:0] r_value;
  logic [2:0] r_count;
  logic       r_malformed;

  logic w_is_soh;
  logic w_is_digit;
  logic w_start;
  logic w_body;
  logic w_enter_trailer;
  logic w_digit;
  logic w_bad_byte;
  logic w_done;
  logic w_malformed_final;
  logic w_ok;

  assign w_is_soh   = (data_i == c_SOH);
  assign w_is_digit = (data_i >= 8'h30) && (data_i <= 8'h39);

  // Trailer verdict, evaluated on the terminating SOH. A value above 255
  // cannot equal an 8-bit sum, so the compare is done at full 10-bit width.
  assign w_malformed_final = r_malformed || (r_count != 3'd3);
  assign w_ok              = !w_malformed_final && (r_value == {2'b00, r_snap});

  // Pass-through pipeline: one cycle of latency regardless of parser state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o       <= 8'h00;
      data_valid_o <= 1'b0;
    end else begin
      data_o       <= data_i;
      data_valid_o <= data_valid_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; stalls (valid low) hold the state.
  always_comb begin
    w_state_next = r_state;
    if (data_valid_i) begin
      case (r_state)
        c_S_IDLE:    if (data_i == c_EIGHT) w_state_next = c_S_BODY;
        c_S_BODY:    if ((r_match == c_M_ZERO) && (data_i == c_EQ)) w_state_next = c_S_TRAILER;
        c_S_TRAILER: if (w_is_soh) w_state_next = c_S_IDLE;
        default:     w_state_next = c_S_IDLE;
      endcase
    end
  end

  // FSM output decode: per-byte events that steer the datapath.
  always_comb begin
    w_start         = 1'b0;
    w_body          = 1'b0;
    w_enter_trailer = 1'b0;
    w_digit         = 1'b0;
    w_bad_byte      = 1'b0;
    w_done          = 1'b0;
    if (data_valid_i) begin
      case (r_state)
        c_S_IDLE: begin
          w_start = (data_i == c_EIGHT);
        end
        c_S_BODY: begin
          w_body          = 1'b1;
          w_enter_trailer = (r_match == c_M_ZERO) && (data_i == c_EQ);
        end
        c_S_TRAILER: begin
          w_digit    = w_is_digit;
          w_bad_byte = !w_is_digit && !w_is_soh;
          w_done     = w_is_soh;
        end
        default: ;
      endcase
    end
  end

  // Body accumulator, SOH snapshot and "10=" matcher.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= 8'h00;
      r_snap  <= 8'h00;
      r_match <= c_M_NONE;
    end else if (w_start) begin
      r_sum   <= c_EIGHT;
      r_match <= c_M_NONE;
    end else if (w_body) begin
      // Sum keeps running through "10=" bytes; only the snapshot is compared.
      r_sum <= r_sum + data_i;
      if (w_is_soh) begin
        r_snap  <= r_sum + data_i;
        r_match <= c_M_SOH;
      end else if ((r_match == c_M_SOH) && (data_i == c_ONE)) begin
        r_match <= c_M_ONE;
      end else if ((r_match == c_M_ONE) && (data_i == c_ZERO)) begin
        r_match <= c_M_ZERO;
      end else begin
        r_match <= c_M_NONE;
      end
    end
  end

  // Trailer digit parser: decimal value, digit count and malformed flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value     <= 10'd0;
      r_count     <= 3'd0;
      r_malformed <= 1'b0;
    end else if (w_enter_trailer) begin
      r_value     <= 10'd0;
      r_count     <= 3'd0;
      r_malformed <= 1'b0;
    end else if (w_digit) begin
      r_value <= (r_value * 10'd10) + {6'd0, data_i[3:0]};
      if (r_count != 3'd7) r_count <= r_count + 3'd1;
      if (r_count >= 3'd3) r_malformed <= 1'b1;
    end else if (w_bad_byte) begin
      r_malformed <= 1'b1;
    end
  end

  // Per-message result registers; held until the next message completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_done_o      <= 1'b0;
      checksum_ok_o   <= 1'b0;
      format_err_o    <= 1'b0;
      checksum_calc_o <= 8'h00;
      checksum_rx_o   <= 8'h00;
    end else begin
      msg_done_o <= w_done;
      if (w_done) begin
        checksum_ok_o   <= w_ok;
        format_err_o    <= w_malformed_final;
        checksum_calc_o <= r_snap;
        checksum_rx_o   <= r_value[7:0];
      end
    end
  end

`ifdef FIX_CSUM_STATS_EN
  logic [15:0] r_good_cnt;
  logic [15:0] r_bad_cnt;

  // Saturating pass/fail message counters, updated with each verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_good_cnt <= 16'h0000;
      r_bad_cnt  <= 16'h0000;
    end else if (w_done) begin
      if (w_ok) begin
        if (r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 16'd1;
      end else begin
        if (r_bad_cnt != 16'hFFFF) r_bad_cnt <= r_bad_cnt + 16'd1;
      end
    end
  end

  assign good_cnt_o = r_good_cnt;
  assign bad_cnt_o  = r_bad_cnt;
`else
  assign good_cnt_o = 16'h0000;
  assign bad_cnt_o  = 16'h0000;
`endif

endmodule
`default_nettype wire
